// File: rtl/wb_snoop_pkg.sv
// Shared definitions for the snoop coherence blocks (responder and arbiter):
// one-hot FSM encoding, response codes, counter widths and a clog2 helper.
package wb_snoop_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_LOOKUP  = 4'b0010,
        ST_INVAL   = 4'b0100,
        ST_RESPOND = 4'b1000
    } snoop_state_e;

    localparam logic RESP_MISS = 1'b0;
    localparam logic RESP_HIT  = 1'b1;

    localparam int TMO_W  = 8;   // timeout counter width (timeout <= 255)
    localparam int STAT_W = 16;  // statistics counter width

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_snoop_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module wb_snoop_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up once per inc pulse, holding at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/wb_snoop_responder.sv
// Per-core snoop responder. Accepts a poll from the snoop arbiter on a rising
// edge of poll_active_i, looks the address up in the local cache, and either
// returns the cached word (read poll) or invalidates the line (write poll).
// Self-snoops answer with a miss without touching the cache. A lookup that is
// not acknowledged within `timeout` cycles is answered with a miss.
// Optional hit/miss/timeout counters: define WB_SNOOP_RESPONDER_STATS_EN.
module wb_snoop_responder
    import wb_snoop_pkg::*;
#(
    parameter int aw        = 32,
    parameter int dw        = 32,
    parameter int num_cores = 2,
    parameter int core_id   = 0,
    parameter int timeout   = 15,
    localparam int sw       = (num_cores > 1) ? clog2(num_cores) : 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          poll_active_i,
    input  logic          snoop_we_i,
    input  logic [aw-1:0] snoop_adr_i,
    input  logic [sw-1:0] snoop_src_i,
    output logic          poll_valid_o,
    output logic          poll_response_o,
    output logic [dw-1:0] snooped_dat_o,
    output logic          cache_lkp_req_o,
    output logic [aw-1:0] cache_lkp_adr_o,
    input  logic          cache_lkp_ack_i,
    input  logic          cache_hit_i,
    input  logic [dw-1:0] cache_dat_i,
`ifdef WB_SNOOP_RESPONDER_STATS_EN
    output logic [STAT_W-1:0] stat_hit_o,
    output logic [STAT_W-1:0] stat_miss_o,
    output logic [STAT_W-1:0] stat_timeout_o,
`endif
    output logic          cache_inv_o
);

    localparam logic [sw-1:0]    SELF_ID = sw'(core_id);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(timeout);

    snoop_state_e     state;
    logic             poll_q;   // previous poll level for edge detection
    logic             we_q;     // captured poll type
    logic [TMO_W-1:0] cnt;      // lookup cycles elapsed
    logic [TMO_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + TMO_W'(1);

    // Control FSM; every output is registered here
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state           <= ST_IDLE;
            poll_q          <= 1'b0;
            we_q            <= 1'b0;
            cnt             <= '0;
            poll_valid_o    <= 1'b0;
            poll_response_o <= RESP_MISS;
            snooped_dat_o   <= '0;
            cache_lkp_req_o <= 1'b0;
            cache_lkp_adr_o <= '0;
            cache_inv_o     <= 1'b0;
        end else begin
            poll_q <= poll_active_i;
            case (state)
                ST_IDLE: begin
                    if (poll_active_i && !poll_q) begin
                        we_q <= snoop_we_i;
                        if (snoop_src_i == SELF_ID) begin
                            state           <= ST_RESPOND;
                            poll_valid_o    <= 1'b1;
                            poll_response_o <= RESP_MISS;
                            snooped_dat_o   <= '0;
                        end else begin
                            state           <= ST_LOOKUP;
                            cnt             <= '0;
                            cache_lkp_req_o <= 1'b1;
                            cache_lkp_adr_o <= snoop_adr_i;
                        end
                    end
                end
                ST_LOOKUP: begin
                    cnt <= cnt_nxt;
                    if (!poll_active_i) begin
                        // Poll withdrawn: drop the request, ignore any ack
                        state           <= ST_IDLE;
                        cache_lkp_req_o <= 1'b0;
                        cache_lkp_adr_o <= '0;
                    end else if (cache_lkp_ack_i) begin
                        // Ack takes priority over a simultaneous timeout
                        cache_lkp_req_o <= 1'b0;
                        if (!we_q) begin
                            state           <= ST_RESPOND;
                            poll_valid_o    <= 1'b1;
                            poll_response_o <= cache_hit_i ? RESP_HIT : RESP_MISS;
                            snooped_dat_o   <= cache_hit_i ? cache_dat_i : '0;
                            cache_lkp_adr_o <= '0;
                        end else if (cache_hit_i) begin
                            // Keep the address for the invalidate strobe
                            state       <= ST_INVAL;
                            cache_inv_o <= 1'b1;
                        end else begin
                            state           <= ST_RESPOND;
                            poll_valid_o    <= 1'b1;
                            poll_response_o <= RESP_MISS;
                            snooped_dat_o   <= '0;
                            cache_lkp_adr_o <= '0;
                        end
                    end else if (cnt_nxt == TMO_LIM) begin
                        state           <= ST_RESPOND;
                        cache_lkp_req_o <= 1'b0;
                        cache_lkp_adr_o <= '0;
                        poll_valid_o    <= 1'b1;
                        poll_response_o <= RESP_MISS;
                        snooped_dat_o   <= '0;
                    end
                end
                ST_INVAL: begin
                    // Single-cycle strobe; a write poll never supplies data
                    state           <= ST_RESPOND;
                    cache_inv_o     <= 1'b0;
                    cache_lkp_adr_o <= '0;
                    poll_valid_o    <= 1'b1;
                    poll_response_o <= RESP_MISS;
                    snooped_dat_o   <= '0;
                end
                ST_RESPOND: begin
                    if (!poll_active_i) begin
                        state           <= ST_IDLE;
                        poll_valid_o    <= 1'b0;
                        poll_response_o <= RESP_MISS;
                        snooped_dat_o   <= '0;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    poll_valid_o    <= 1'b0;
                    poll_response_o <= RESP_MISS;
                    snooped_dat_o   <= '0;
                    cache_lkp_req_o <= 1'b0;
                    cache_lkp_adr_o <= '0;
                    cache_inv_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_SNOOP_RESPONDER_STATS_EN
    logic ev_hit, ev_miss, ev_tmo;

    // Outcome of a non-self poll, asserted on the edge that enters RESPOND
    always_comb begin
        ev_hit  = 1'b0;
        ev_miss = 1'b0;
        ev_tmo  = 1'b0;
        if (state == ST_LOOKUP && poll_active_i) begin
            if (cache_lkp_ack_i) begin
                if (!cache_hit_i)  ev_miss = 1'b1;
                else if (!we_q)    ev_hit  = 1'b1;
            end else if (cnt_nxt == TMO_LIM) begin
                ev_tmo = 1'b1;
            end
        end else if (state == ST_INVAL) begin
            ev_hit = 1'b1;
        end
    end

    wb_snoop_sat_cnt #(.W(STAT_W)) u_stat_hit (
        .clk(wb_clk_i), .rst_n(wb_rst_ni), .inc(ev_hit), .cnt(stat_hit_o)
    );
    wb_snoop_sat_cnt #(.W(STAT_W)) u_stat_miss (
        .clk(wb_clk_i), .rst_n(wb_rst_ni), .inc(ev_miss), .cnt(stat_miss_o)
    );
    wb_snoop_sat_cnt #(.W(STAT_W)) u_stat_tmo (
        .clk(wb_clk_i), .rst_n(wb_rst_ni), .inc(ev_tmo), .cnt(stat_timeout_o)
    );
`endif

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Directed bench for wb_snoop_responder (core_id 0, two cores, timeout 4).
module tb_wb_snoop_responder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 1;

    logic          clk;
    logic          rst_n;
    logic          poll;
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] src;
    logic          valid;
    logic          resp;
    logic [DW-1:0] sdat;
    logic          req;
    logic [AW-1:0] ladr;
    logic          ack;
    logic          hit;
    logic [DW-1:0] cdat;
    logic          inv;
`ifdef WB_SNOOP_RESPONDER_STATS_EN
    logic [15:0]   s_hit, s_miss, s_tmo;
`endif

    int n_vec = 0;
    int n_err = 0;

    wb_snoop_responder #(
        .aw(AW), .dw(DW), .num_cores(2), .core_id(0), .timeout(4)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .poll_active_i   (poll),
        .snoop_we_i      (we),
        .snoop_adr_i     (adr),
        .snoop_src_i     (src),
        .poll_valid_o    (valid),
        .poll_response_o (resp),
        .snooped_dat_o   (sdat),
        .cache_lkp_req_o (req),
        .cache_lkp_adr_o (ladr),
        .cache_lkp_ack_i (ack),
        .cache_hit_i     (hit),
        .cache_dat_i     (cdat),
`ifdef WB_SNOOP_RESPONDER_STATS_EN
        .stat_hit_o      (s_hit),
        .stat_miss_o     (s_miss),
        .stat_timeout_o  (s_tmo),
`endif
        .cache_inv_o     (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag, input int eh, input int em, input int et);
`ifdef WB_SNOOP_RESPONDER_STATS_EN
        chk({tag, "_stat_hit"},  64'(s_hit),  64'(eh));
        chk({tag, "_stat_miss"}, 64'(s_miss), 64'(em));
        chk({tag, "_stat_tmo"},  64'(s_tmo),  64'(et));
`else
        if (eh < 0 || em < 0 || et < 0) $display("bad stats args for %s", tag);
`endif
    endtask

    task automatic chk_out(input string tag, input logic v, input logic r,
                           input logic [DW-1:0] d, input logic q, input logic i);
        chk({tag, "_valid"}, 64'(valid), 64'(v));
        chk({tag, "_resp"},  64'(resp),  64'(r));
        chk({tag, "_dat"},   64'(sdat),  64'(d));
        chk({tag, "_req"},   64'(req),   64'(q));
        chk({tag, "_inv"},   64'(inv),   64'(i));
    endtask

    initial begin
        rst_n = 1'b0; poll = 1'b0; we = 1'b0; adr = '0; src = '0;
        ack = 1'b0; hit = 1'b0; cdat = '0;
        #2;
        chk_out("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("reset_ladr", 64'(ladr), 64'h0);
        chk_stats("reset", 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Read hit, ack in cycle 1
        poll = 1'b1; we = 1'b0; adr = 32'h0000_1000; src = 1'b1;
        tick();
        chk_out("rd_c1", 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("rd_c1_ladr", 64'(ladr), 64'h1000);
        ack = 1'b1; hit = 1'b1; cdat = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0; hit = 1'b0; cdat = '0;
        chk_out("rd_c2", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk_stats("rd", 1, 0, 0);
        tick(); tick();
        chk_out("rd_hold", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        poll = 1'b0;
        tick();
        chk_out("rd_drop", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Write hit: one invalidate pulse in cycle 2, valid miss in cycle 3
        poll = 1'b1; we = 1'b1; adr = 32'h0000_2000; src = 1'b1;
        tick();
        chk("wr_c1_req", 64'(req), 64'h1);
        ack = 1'b1; hit = 1'b1; cdat = 32'h1234_5678;
        tick();
        ack = 1'b0; hit = 1'b0; cdat = '0;
        chk_out("wr_c2", 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("wr_c2_ladr", 64'(ladr), 64'h2000);
        tick();
        chk_out("wr_c3", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk_stats("wr", 2, 0, 0);
        poll = 1'b0;
        tick();
        chk_out("wr_drop", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Self-snoop: no lookup, miss in cycle 1, not counted
        poll = 1'b1; we = 1'b0; adr = 32'h0000_3000; src = 1'b0;
        tick();
        chk_out("self_c1", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk_stats("self", 2, 0, 0);
        poll = 1'b0;
        tick();
        chk_out("self_drop", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Timeout: request held cycles 1..4, miss in cycle 5
        poll = 1'b1; we = 1'b0; adr = 32'h0000_4000; src = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("tmo_c%0d_req", c), 64'(req), 64'h1);
            chk($sformatf("tmo_c%0d_valid", c), 64'(valid), 64'h0);
        end
        tick();
        chk_out("tmo_c5", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk_stats("tmo", 2, 0, 1);
        poll = 1'b0;
        tick();
        tick();

        // Ack in the same cycle the counter expires: ack wins
        poll = 1'b1; we = 1'b0; adr = 32'h0000_4400; src = 1'b1;
        tick(); tick(); tick(); tick();
        ack = 1'b1; hit = 1'b1; cdat = 32'hCAFE_F00D;
        tick();
        ack = 1'b0; hit = 1'b0; cdat = '0;
        chk_out("tmo_ack", 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk_stats("tmo_ack", 3, 0, 1);
        poll = 1'b0;
        tick();
        tick();

        // Read miss: data is forced to zero
        poll = 1'b1; we = 1'b0; adr = 32'h0000_5000; src = 1'b1;
        tick();
        ack = 1'b1; hit = 1'b0; cdat = 32'hFFFF_FFFF;
        tick();
        ack = 1'b0; cdat = '0;
        chk_out("rmiss", 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk_stats("rmiss", 3, 1, 1);
        poll = 1'b0;
        tick();
        tick();

        // Abort: poll drops in LOOKUP cycle 2 together with an ack
        poll = 1'b1; we = 1'b0; adr = 32'h0000_6000; src = 1'b1;
        tick();
        tick();
        chk("abort_c2_req", 64'(req), 64'h1);
        poll = 1'b0; ack = 1'b1; hit = 1'b1; cdat = 32'h5555_AAAA;
        tick();
        ack = 1'b0; hit = 1'b0; cdat = '0;
        chk_out("abort_c3", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("abort_idle%0d_valid", c), 64'(valid), 64'h0);
        end
        chk_stats("abort", 3, 1, 1);

        // Async reset while in RESPOND
        poll = 1'b1; we = 1'b0; adr = 32'h0000_7000; src = 1'b1;
        tick();
        ack = 1'b1; hit = 1'b1; cdat = 32'h0BAD_F00D;
        tick();
        ack = 1'b0; hit = 1'b0; cdat = '0;
        chk("rst_pre_valid", 64'(valid), 64'h1);
        #2;
        rst_n = 1'b0; poll = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk_stats("rst_async", 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst_idle%0d_valid", c), 64'(valid), 64'h0);
            chk($sformatf("rst_idle%0d_req", c), 64'(req), 64'h0);
        end
        // Fresh poll edge after reset is served normally
        poll = 1'b1; adr = 32'h0000_8000; src = 1'b1;
        tick();
        chk("post_rst_req", 64'(req), 64'h1);
        ack = 1'b1; hit = 1'b1; cdat = 32'h0000_00A5;
        tick();
        ack = 1'b0; hit = 1'b0; cdat = '0;
        chk_out("post_rst", 1'b1, 1'b1, 32'h0000_00A5, 1'b0, 1'b0);
        poll = 1'b0;
        tick();
        chk("post_rst_drop", 64'(valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_snoop_responder.md
# wb_snoop_responder

Per-core snoop responder for the shared-bus coherence scheme: sits between the snoop arbiter's broadcast snoop channel and one core's data cache. On each poll it looks the snooped address up in the local cache. For a read poll it returns hit/miss plus the cached word; for a write poll it invalidates the local copy. One instance per core, `core_id` distinguishing them.

## Interface
- `aw`, default 32: address width.
- `dw`, default 32: data width.
- `num_cores`, default 2: cores on the snoop broadcast. `sw = num_cores > 1 ? clog2(num_cores) : 1`.
- `core_id`, default 0: index of the owning core; snoops with source equal to this are self-snoops.
- `timeout`, default 15: maximum lookup cycles before a forced miss; legal range 1–255.
- `wb_clk_i` in 1: the block's single clock.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `poll_active_i` in 1: arbiter poll request, level; held until response consumed.
- `snoop_we_i` in 1: 1 = write poll (invalidate), 0 = read poll.
- `snoop_adr_i` in aw: snooped address.
- `snoop_src_i` in sw: index of the requesting core.
- `poll_valid_o` out 1: response valid.
- `poll_response_o` out 1: 1 = local hit, data supplied.
- `snooped_dat_o` out dw: supplied word; 0 when `poll_response_o` = 0.
- `cache_lkp_req_o` out 1: lookup request to local cache.
- `cache_lkp_adr_o` out aw: lookup or invalidate address.
- `cache_lkp_ack_i` in 1: lookup done; `cache_hit_i` and `cache_dat_i` are valid in this cycle.
- `cache_hit_i` in 1: lookup hit.
- `cache_dat_i` in dw: hit data.
- `cache_inv_o` out 1: one-cycle invalidate strobe for `cache_lkp_adr_o`.

## Operation
- FSM states: IDLE, LOOKUP, INVAL, RESPOND. Reset state is IDLE.
- Reset values: all outputs and registers 0.
- **IDLE**
  - On a rising edge of `poll_active_i` (registered previous value 0, current 1), capture `snoop_adr_i`, `snoop_we_i` and `snoop_src_i`.
  - If the captured source equals `core_id`, go to RESPOND with a miss.
  - Otherwise go to LOOKUP and clear the timeout counter.
- **LOOKUP**
  - `cache_lkp_req_o` = 1 and `cache_lkp_adr_o` = captured address; the counter increments every cycle.
  - On `cache_lkp_ack_i`:
    - read poll: latch hit and `hit ? cache_dat_i : 0`, go to RESPOND.
    - write poll with hit: go to INVAL.
    - write poll with miss: go to RESPOND with a miss.
  - Counter reaches `timeout` without an ack: go to RESPOND with a miss.
  - Ack arrives in the same cycle the counter reaches `timeout`: the ack wins.
- **INVAL**
  - `cache_inv_o` = 1 for exactly one cycle, then go to RESPOND.
  - A write poll always responds with `poll_response_o` = 0.
- **RESPOND**
  - `poll_valid_o` = 1; response and data are held stable.
  - When `poll_active_i` is low: go to IDLE and clear the outputs in the next cycle.
- **Abort:** `poll_active_i` falling during LOOKUP drops the request and returns to IDLE; an ack in that same cycle is ignored. INVAL always completes, then RESPOND exits immediately because the poll is already low.
- A new poll is only recognised from IDLE. A poll held high across RESPOND→IDLE is not re-accepted; it needs a fresh rising edge.

## Timing
- Rising edge sampled at cycle 0; `cache_lkp_req_o` high in cycle 1.
- Read hit with ack in cycle 1: `poll_valid_o` high in cycle 2. Minimum latency is 2 cycles.
- Write hit with ack in cycle 1: `cache_inv_o` in cycle 2, `poll_valid_o` in cycle 3.
- Self-snoop: `poll_valid_o` in cycle 1.
- Timeout: `poll_valid_o` in cycle `timeout`+1 after the edge.
- `poll_valid_o` deasserts in the cycle after `poll_active_i` is sampled low.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `WB_SNOOP_RESPONDER_STATS_EN` defined:
  - adds outputs `stat_hit_o`, `stat_miss_o`, `stat_timeout_o`, each 16 bits, saturating, reset to 0.
  - each increments once per completed poll in the cycle RESPOND is entered.
  - self-snoops are not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `wb_snoop_pkg`: FSM state encoding (one-hot, 4 bits), the response-code constants, and the `clog2` helper. The snoop arbiter imports the same package.
- Sub-module `wb_snoop_sat_cnt`: parameterised-width saturating counter, instantiated three times under the macro.
- The FSM, capture registers and timeout counter stay in the top level.

## Test plan
- Read poll, adr 0x0000_1000, src 1, core_id 0, ack+hit in cycle 1 with data 0xDEAD_BEEF -> `poll_valid_o` = 1, response = 1 and data 0xDEAD_BEEF in cycle 2, held until the poll drops.
- Write poll, adr 0x0000_2000, hit -> exactly one `cache_inv_o` pulse with that address in cycle 2, then valid with response 0 in cycle 3.
- Self-snoop, src = core_id = 0 -> no `cache_lkp_req_o`; valid/miss in cycle 1.
- Timeout = 4, no ack -> request held 4 cycles, then valid with miss and data 0; with stats enabled, `stat_timeout_o` = 1. Ack in cycle 4 -> treated as hit.
- Abort: poll drops in cycle 2 of LOOKUP with an ack in the same cycle -> back to IDLE; `poll_valid_o` never asserts and no counter increments.
- Reset asserted asynchronously while in RESPOND -> all outputs 0 immediately; the FSM returns to IDLE and needs a fresh poll edge to respond.
